// File: rtl/modexp_arbiter.sv
// modexp_arbiter: two-requester round-robin front end for a shared modexp engine.
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   req[1:0], msg0, msg1  requests and their operands (held until granted)
//   gnt[1:0]              one-cycle grant pulse when an operand is latched
//   resp_valid[1:0]       one-cycle result pulse to the owning requester
//   resp_data, resp_err   result (0 when not valid) and timeout-abort flag
//   busy                  high whenever a transaction is in flight
//   cfg_we/sel/data       key writes (sel 0 = exponent, 1 = modulus)
//   cfg_err               one-cycle pulse when a key write is dropped
//   eng_start, eng_msg    engine start pulse and latched operand
//   eng_key, update_e/n   key value and its one-cycle load strobes
//   eng_done, eng_result  engine completion pulse and result
// All outputs are registered; each pulse is high during the cycle of the
// state that produces it (gnt/eng_start in GRANT, resp_valid in RESP).
module modexp_arbiter #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] msg0,
  input  logic [W-1:0] msg1,
  output logic [1:0]   gnt,
  output logic [1:0]   resp_valid,
  output logic [W-1:0] resp_data,
  output logic         resp_err,
  output logic         busy,
  input  logic         cfg_we,
  input  logic         cfg_sel,
  input  logic [W-1:0] cfg_data,
  output logic         cfg_err,
  output logic         eng_start,
  output logic [W-1:0] eng_msg,
  output logic [W-1:0] eng_key,
  output logic         update_e,
  output logic         update_n,
  input  logic         eng_done,
  input  logic [W-1:0] eng_result
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, RESP} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_q, last_d;
  logic           owner_q, owner_d;
  logic           win_c;

  logic [1:0]     gnt_d, resp_valid_d;
  logic [W-1:0]   resp_data_d, eng_msg_d, eng_key_d;
  logic           resp_err_d, busy_d, cfg_err_d, eng_start_d, update_e_d, update_n_d;

  // Round-robin pick: on contention favour the requester not granted last.
  assign win_c = (req == 2'b11) ? ~last_q : req[1];

  // Next-state and next-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    owner_d      = owner_q;
    gnt_d        = 2'b00;
    resp_valid_d = 2'b00;
    resp_data_d  = '0;
    resp_err_d   = 1'b0;
    cfg_err_d    = 1'b0;
    eng_start_d  = 1'b0;
    update_e_d   = 1'b0;
    update_n_d   = 1'b0;
    eng_msg_d    = eng_msg;
    eng_key_d    = eng_key;

    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d     = win_c;
          last_d      = win_c;
          eng_msg_d   = win_c ? msg1 : msg0;
          gnt_d       = win_c ? 2'b10 : 2'b01;
          eng_start_d = 1'b1;
          cfg_err_d   = cfg_we;   // request wins over a coincident key write
          state_d     = GRANT;
        end else if (cfg_we) begin
          eng_key_d  = cfg_data;
          update_e_d = ~cfg_sel;
          update_n_d = cfg_sel;
        end
      end
      GRANT: begin
        cfg_err_d = cfg_we;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        cfg_err_d = cfg_we;
        // Completion takes precedence over a timeout in the same cycle.
        if (eng_done) begin
          resp_valid_d = owner_q ? 2'b10 : 2'b01;
          resp_data_d  = eng_result;
          state_d      = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          resp_valid_d = owner_q ? 2'b10 : 2'b01;
          resp_err_d   = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        cfg_err_d = cfg_we;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      gnt        <= 2'b00;
      resp_valid <= 2'b00;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
      eng_start  <= 1'b0;
      eng_msg    <= '0;
      eng_key    <= '0;
      update_e   <= 1'b0;
      update_n   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      gnt        <= gnt_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
      resp_err   <= resp_err_d;
      busy       <= busy_d;
      cfg_err    <= cfg_err_d;
      eng_start  <= eng_start_d;
      eng_msg    <= eng_msg_d;
      eng_key    <= eng_key_d;
      update_e   <= update_e_d;
      update_n   <= update_n_d;
    end
  end

endmodule

// File: tb/tb_modexp_arbiter.sv
// Self-checking bench for modexp_arbiter: timestamp-based transaction model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_modexp_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] msg0, msg1;
  logic [1:0]   gnt, resp_valid;
  logic [W-1:0] resp_data;
  logic         resp_err, busy;
  logic         cfg_we, cfg_sel;
  logic [W-1:0] cfg_data;
  logic         cfg_err, eng_start;
  logic [W-1:0] eng_msg, eng_key;
  logic         update_e, update_n;
  logic         eng_done;
  logic [W-1:0] eng_result;

  // Engine emulation and manual injection drive eng_done through one net.
  logic         done_eng = 1'b0, done_inj = 1'b0;
  logic [W-1:0] res_eng = '0, inj_res = '0, eng_res_cfg = '0;
  int           eng_lat = 0;
  int           pend = 0;
  logic         s_start;
  assign eng_done   = done_eng | done_inj;
  assign eng_result = done_inj ? inj_res : res_eng;

  int total = 0;
  int bad   = 0;

  modexp_arbiter #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .msg0(msg0), .msg1(msg1),
    .gnt(gnt), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .eng_start(eng_start),
    .eng_msg(eng_msg), .eng_key(eng_key), .update_e(update_e),
    .update_n(update_n), .eng_done(eng_done), .eng_result(eng_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Engine: eng_done arrives eng_lat cycles after the eng_start cycle (0 = never).
  always @(posedge clk) begin
    s_start = eng_start;
    #1;
    done_eng = 1'b0;
    res_eng  = '0;
    if (rst) pend = 0;
    else if (s_start && eng_lat > 0) pend = eng_lat;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        done_eng = 1'b1;
        res_eng  = eng_res_cfg;
      end
    end
  end

  // Transaction model: a transaction is timed by its age since the grant
  // cycle (age 0); ages 1..TO are engine-wait cycles, then one response cycle.
  logic         m_active = 1'b0, m_resp = 1'b0, m_last = 1'b1, m_owner = 1'b0;
  int           m_age = 0;
  logic [1:0]   e_gnt = '0, e_rv = '0;
  logic [W-1:0] e_rd = '0, e_msg = '0, e_key = '0;
  logic         e_re = 0, e_busy = 0, e_cerr = 0, e_start = 0, e_ue = 0, e_un = 0;

  always @(posedge clk) begin
    e_gnt = '0; e_rv = '0; e_rd = '0; e_re = 0; e_cerr = 0;
    e_start = 0; e_ue = 0; e_un = 0;
    if (rst) begin
      m_active = 0; m_resp = 0; m_last = 1; m_age = 0;
      e_msg = '0; e_key = '0;
    end else if (!m_active) begin
      if (req != 2'b00) begin
        m_owner  = (req == 2'b11) ? ~m_last : req[1];
        m_last   = m_owner;
        e_gnt    = m_owner ? 2'b10 : 2'b01;
        e_msg    = m_owner ? msg1 : msg0;
        e_start  = 1;
        e_cerr   = cfg_we;
        m_active = 1;
        m_age    = 0;
      end else if (cfg_we) begin
        e_key = cfg_data;
        if (cfg_sel) e_un = 1; else e_ue = 1;
      end
    end else begin
      e_cerr = cfg_we;
      if (m_resp) begin
        m_active = 0;
        m_resp   = 0;
      end else if (m_age >= 1 && eng_done) begin
        m_resp = 1;
        e_rv   = m_owner ? 2'b10 : 2'b01;
        e_rd   = eng_result;
      end else if (m_age == TO) begin
        m_resp = 1;
        e_rv   = m_owner ? 2'b10 : 2'b01;
        e_re   = 1;
      end else begin
        m_age++;
      end
    end
    e_busy = m_active;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("gnt", W'(gnt), W'(e_gnt));
    check("resp_valid", W'(resp_valid), W'(e_rv));
    check("resp_data", resp_data, e_rd);
    check("resp_err", W'(resp_err), W'(e_re));
    check("busy", W'(busy), W'(e_busy));
    check("cfg_err", W'(cfg_err), W'(e_cerr));
    check("eng_start", W'(eng_start), W'(e_start));
    check("update_e", W'(update_e), W'(e_ue));
    check("update_n", W'(update_n), W'(e_un));
    check("eng_msg", eng_msg, e_msg);
    check("eng_key", eng_key, e_key);
    check("onehot", W'(($countones(gnt) <= 1) && ($countones(resp_valid) <= 1)
                       && !(update_e && update_n)), W'(1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait: sel 0 = any gnt, 1 = any resp_valid; n = cycles waited.
  task automatic wait_until(input int sel, input string nm, output int n);
    bit hit;
    hit = 0;
    n   = 0;
    while (!hit && n < 64) begin
      tick();
      n++;
      hit = (sel == 0) ? (|gnt) : (|resp_valid);
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL %s: no event within %0d cycles", nm, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; req = '0; msg0 = '0; msg1 = '0;
    cfg_we = 0; cfg_sel = 0; cfg_data = '0;
    do_reset();
    check("rst_busy", W'(busy), W'(0));
    check("rst_gnt", W'(gnt), W'(0));
    check("rst_rv", W'(resp_valid), W'(0));

    // Single request, engine answers 3 cycles after eng_start.
    eng_lat = 3; eng_res_cfg = 32'h1A;
    req = 2'b01; msg0 = 32'h5;
    wait_until(0, "single_gnt", n);
    check("single_req2gnt", W'(n), W'(1));
    check("single_gnt", W'(gnt), W'(2'b01));
    check("single_start", W'(eng_start), W'(1));
    check("single_msg", eng_msg, 32'h5);
    req = 2'b00;
    wait_until(1, "single_resp", n);
    check("single_lat", W'(n), W'(4));
    check("single_rv", W'(resp_valid), W'(2'b01));
    check("single_rd", resp_data, 32'h1A);
    check("single_re", W'(resp_err), W'(0));
    tick();
    check("single_idle", W'(busy), W'(0));

    // Key writes in IDLE.
    cfg_we = 1; cfg_sel = 1; cfg_data = 32'hC5;
    tick();
    check("cfg_un", W'(update_n), W'(1));
    check("cfg_ue0", W'(update_e), W'(0));
    check("cfg_key", eng_key, 32'hC5);
    cfg_sel = 0; cfg_data = 32'h11;
    tick();
    check("cfg_ue", W'(update_e), W'(1));
    check("cfg_key_e", eng_key, 32'h11);
    cfg_we = 0;
    tick();
    check("cfg_ue_pulse", W'(update_e), W'(0));

    // Contention from reset: 01, 10, 01.
    do_reset();
    eng_lat = 2; eng_res_cfg = 32'h1234;
    msg0 = 32'hA0; msg1 = 32'hB1; req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wait_until(0, "rr_gnt", n);
      check("rr_gnt", W'(gnt), (i % 2 == 0) ? W'(2'b01) : W'(2'b10));
      check("rr_msg", eng_msg, (i % 2 == 0) ? 32'hA0 : 32'hB1);
      wait_until(1, "rr_resp", n);
      check("rr_rv", W'(resp_valid), (i % 2 == 0) ? W'(2'b01) : W'(2'b10));
      check("rr_rd", resp_data, 32'h1234);
      if (i == 2) req = 2'b00;
    end

    // Timeout with a key write landing in WAIT.
    eng_lat = 0;
    req = 2'b10; msg1 = 32'h77;
    wait_until(0, "to_gnt", n);
    req = 2'b00;
    tick();
    cfg_we = 1; cfg_sel = 1; cfg_data = 32'hC5;
    tick();
    check("wait_cfg_err", W'(cfg_err), W'(1));
    check("wait_no_un", W'(update_n), W'(0));
    cfg_we = 0;
    wait_until(1, "to_resp", n);
    check("to_lat", W'(n + 1), W'(TO));
    check("to_rv", W'(resp_valid), W'(2'b10));
    check("to_re", W'(resp_err), W'(1));
    check("to_rd", resp_data, 32'h0);

    // eng_done on the last WAIT cycle beats the timeout.
    eng_lat = 8; eng_res_cfg = 32'h5A5A;
    req = 2'b01; msg0 = 32'h3;
    wait_until(0, "tie_gnt", n);
    req = 2'b00;
    wait_until(1, "tie_resp", n);
    check("tie_lat", W'(n), W'(9));
    check("tie_re", W'(resp_err), W'(0));
    check("tie_rd", resp_data, 32'h5A5A);

    // eng_done one cycle too late lands in RESP and is ignored.
    eng_lat = 9; eng_res_cfg = 32'h6B6B;
    req = 2'b01;
    wait_until(0, "late_gnt", n);
    req = 2'b00;
    wait_until(1, "late_resp", n);
    check("late_lat", W'(n), W'(9));
    check("late_re", W'(resp_err), W'(1));
    check("late_rd", resp_data, 32'h0);
    tick();

    // Reset in WAIT abandons the transaction; a stray eng_done is ignored.
    eng_lat = 0;
    req = 2'b10; msg1 = 32'h42;
    wait_until(0, "rm_gnt", n);
    req = 2'b00;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rm_busy", W'(busy), W'(0));
    rst = 1'b0;
    done_inj = 1; inj_res = 32'hDEAD;
    tick();
    done_inj = 0;
    check("rm_rv0", W'(resp_valid), W'(0));
    tick();
    check("rm_rv1", W'(resp_valid), W'(0));
    check("rm_busy2", W'(busy), W'(0));
    eng_lat = 1; eng_res_cfg = 32'h7;
    req = 2'b10; cfg_we = 1; cfg_sel = 0; cfg_data = 32'h99;
    tick();
    check("rm_gnt", W'(gnt), W'(2'b10));
    check("rm_cfg_err", W'(cfg_err), W'(1));
    check("rm_no_ue", W'(update_e), W'(0));
    req = 2'b00; cfg_we = 0;
    wait_until(1, "rm_resp", n);
    check("rm_lat", W'(n), W'(2));
    check("rm_rv", W'(resp_valid), W'(2'b10));
    check("rm_rd", resp_data, 32'h7);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
